// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU and its downstream result FIFO.
// Holds the default widths/depths and the result-beat layout {overflow, data}.
package alu_pkg;

  localparam int unsigned ALU_DATA_WIDTH  = 32;
  localparam int unsigned FIFO_DEPTH      = 8;
  localparam int unsigned FIFO_ADDR_WIDTH = 3;
  localparam int unsigned DROP_CNT_WIDTH  = 16;

  // One ALU result beat; the FIFO stores beats in exactly this bit order.
  typedef struct packed {
    logic                      overflow;
    logic [ALU_DATA_WIDTH-1:0] data;
  } alu_beat_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Result-beat bus between the ALU, the result FIFO and its consumer.
//   i_data/i_overflow/i_valid : beat from the ALU (no backpressure)
//   i_ready                   : consumer ready
//   o_data/o_overflow/o_valid : FIFO head presented to the consumer
// slave  : the FIFO side (consumes ALU beats, drives the head)
// master : the environment side (drives ALU beats and ready, sees the head)
interface alu_result_fifo_if
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_overflow;
  logic                  i_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_overflow;
  logic                  o_valid;

  modport slave (
    input  i_data, i_overflow, i_valid, i_ready,
    output o_data, o_overflow, o_valid
  );

  modport master (
    output i_data, i_overflow, i_valid, i_ready,
    input  o_data, o_overflow, o_valid
  );

endinterface

// File: rtl/alu_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_inc        : count up by one (holds at all-ones)
//   i_clr        : clear; clear together with inc yields 1
//   o_count      : current value
module alu_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= i_inc ? WIDTH'(1) : '0;
    end else if (i_inc && (o_count != '1)) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_result_fifo.sv
// Result FIFO behind the registered ALU. Captures every valid ALU beat,
// presents the oldest one first-word-fall-through with valid/ready, counts
// beats lost while full (saturating) and keeps a sticky overflow flag.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   bus           : beat input from the ALU and head output to the consumer
//   i_clr_status  : synchronous clear of o_ovf_sticky and o_drop_cnt
//   o_count       : occupancy 0..DEPTH
//   o_full        : occupancy == DEPTH
//   o_ovf_sticky  : some accepted beat carried overflow=1
//   o_drop_cnt    : beats dropped while full
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int unsigned DROP_WIDTH = DROP_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  alu_result_fifo_if.slave      bus,
  input  logic                  i_clr_status,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_ovf_sticky,
  output logic [DROP_WIDTH-1:0] o_drop_cnt
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  // Entries are {overflow, data}, matching alu_beat_t.
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [DATA_WIDTH:0]   head;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  not_empty;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  always_comb begin
    not_empty = (count != '0);
    full      = (count == FULL_COUNT);
    pop       = not_empty & bus.i_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    push      = bus.i_valid & (~full | pop);
    drop      = bus.i_valid & full & ~pop;
  end

  // Storage is not reset; the head is masked while empty instead.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.i_overflow, bus.i_data};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (push && !pop) begin
        count <= count + (ADDR_WIDTH+1)'(1);
      end else if (pop && !push) begin
        count <= count - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Set has priority over clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ovf_sticky <= 1'b0;
    end else if (push && bus.i_overflow) begin
      o_ovf_sticky <= 1'b1;
    end else if (i_clr_status) begin
      o_ovf_sticky <= 1'b0;
    end
  end

  alu_sat_counter #(
    .WIDTH (DROP_WIDTH)
  ) u_drop_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (drop),
    .i_clr   (i_clr_status),
    .o_count (o_drop_cnt)
  );

  assign head           = mem[rd_ptr];
  assign bus.o_valid    = not_empty;
  assign bus.o_data     = not_empty ? head[DATA_WIDTH-1:0] : '0;
  assign bus.o_overflow = not_empty & head[DATA_WIDTH];
  assign o_count        = count;
  assign o_full         = full;

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int DW    = ALU_DATA_WIDTH;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DRW   = 16;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_clr_status = 1'b0;
  logic [AW:0]    o_count;
  logic           o_full;
  logic           o_ovf_sticky;
  logic [DRW-1:0] o_drop_cnt;

  alu_result_fifo_if #(.DATA_WIDTH(DW)) bus ();

  alu_result_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .DROP_WIDTH (DRW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .bus          (bus),
    .i_clr_status (i_clr_status),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_ovf_sticky (o_ovf_sticky),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of beats plus the two status values.
  logic [DW:0] mq[$];
  logic        m_sticky;
  int unsigned m_drop;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mq.delete();
      m_sticky = 1'b0;
      m_drop   = 0;
    end else begin
      bit m_pop, m_push, m_drp;
      m_pop  = (mq.size() > 0) && bus.i_ready;
      m_push = bus.i_valid && ((mq.size() < DEPTH) || m_pop);
      m_drp  = bus.i_valid && !m_push;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back({bus.i_overflow, bus.i_data});
      if (m_push && bus.i_overflow) m_sticky = 1'b1;
      else if (i_clr_status) m_sticky = 1'b0;
      if (i_clr_status) m_drop = m_drp ? 1 : 0;
      else if (m_drp && m_drop < 65535) m_drop++;
    end
  end

  // Outputs depend only on registered state, so sampling on the falling edge
  // is unaffected by inputs changed at the same edge.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("m_valid",  64'(bus.o_valid),  64'(mq.size() != 0));
      chk("m_count",  64'(o_count),      64'(mq.size()));
      chk("m_full",   64'(o_full),       64'(mq.size() == DEPTH));
      chk("m_sticky", 64'(o_ovf_sticky), 64'(m_sticky));
      chk("m_drop",   64'(o_drop_cnt),   64'(m_drop));
      if (mq.size() != 0) begin
        chk("m_data", 64'(bus.o_data),     64'(mq[0][DW-1:0]));
        chk("m_ovf",  64'(bus.o_overflow), 64'(mq[0][DW]));
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ovf,
                       input logic r, input logic clr);
    bus.i_valid    = v;
    bus.i_data     = d;
    bus.i_overflow = ovf;
    bus.i_ready    = r;
    i_clr_status   = clr;
    @(negedge i_clk);
  endtask

  initial begin
    bus.i_valid    = 1'b0;
    bus.i_data     = '0;
    bus.i_overflow = 1'b0;
    bus.i_ready    = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_valid",  64'(bus.o_valid),    64'd0);
    chk("rst_count",  64'(o_count),        64'd0);
    chk("rst_full",   64'(o_full),         64'd0);
    chk("rst_sticky", 64'(o_ovf_sticky),   64'd0);
    chk("rst_drop",   64'(o_drop_cnt),     64'd0);
    chk("rst_data",   64'(bus.o_data),     64'd0);
    chk("rst_ovf",    64'(bus.o_overflow), 64'd0);
    i_rst = 1'b0;

    // 1: single beat, then pop
    drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 64'(bus.o_valid), 64'd1);
    chk("t1_data",  64'(bus.o_data),  64'd5);
    chk("t1_count", 64'(o_count),     64'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t1_empty", 64'(bus.o_valid), 64'd0);

    // 2: overfill by two, then drain in order
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      if (i == 7) chk("t2_notfull", 64'(o_full), 64'd0);
      if (i == 8) chk("t2_full",    64'(o_full), 64'd1);
    end
    chk("t2_drop",  64'(o_drop_cnt), 64'd2);
    chk("t2_count", 64'(o_count),    64'd8);
    for (int k = 1; k <= 8; k++) begin
      chk("t2_order", 64'(bus.o_data), 64'(k));
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    chk("t2_empty", 64'(bus.o_valid), 64'd0);

    // 3: streaming through a full FIFO across pointer wrap
    for (int i = 1; i <= 8; i++) drive(1'b1, DW'(100 + i), 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, DW'(200 + j), 1'b0, 1'b1, 1'b0);
      chk("t3_count", 64'(o_count), 64'd8);
    end
    chk("t3_drop", 64'(o_drop_cnt), 64'd2);
    chk("t3_head", 64'(bus.o_data), 64'd212);
    repeat (8) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t3_empty", 64'(bus.o_valid), 64'd0);

    // 4: sticky overflow, set beats clear
    drive(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    chk("t4_sticky", 64'(o_ovf_sticky),   64'd1);
    chk("t4_data",   64'(bus.o_data),     64'h7FFF_FFFF);
    chk("t4_ovf",    64'(bus.o_overflow), 64'd1);
    drive(1'b1, 32'h3, 1'b1, 1'b1, 1'b1);
    chk("t4_setwins", 64'(o_ovf_sticky), 64'd1);
    chk("t4_dropclr", 64'(o_drop_cnt),   64'd0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("t4_clr",   64'(o_ovf_sticky), 64'd0);
    chk("t4_empty", 64'(bus.o_valid),  64'd0);

    // 5: asynchronous reset with entries held
    for (int i = 0; i < 5; i++) drive(1'b1, DW'(32'h50 + i), (i == 2), 1'b0, 1'b0);
    chk("t5_count",  64'(o_count),      64'd5);
    chk("t5_sticky", 64'(o_ovf_sticky), 64'd1);
    bus.i_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("t5_valid",  64'(bus.o_valid),  64'd0);
    chk("t5_rcount", 64'(o_count),      64'd0);
    chk("t5_drop",   64'(o_drop_cnt),   64'd0);
    chk("t5_rstick", 64'(o_ovf_sticky), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(1'b1, 32'hABCD, 1'b0, 1'b0, 1'b0);
    chk("t5_head",  64'(bus.o_data), 64'hABCD);
    chk("t5_count1", 64'(o_count),   64'd1);

    // 6: drop counter saturation and clear-with-drop
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    repeat (70000) drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("t6_sat",   64'(o_drop_cnt), 64'hFFFF);
    chk("t6_count", 64'(o_count),    64'd8);
    chk("t6_head",  64'(bus.o_data), 64'd1);
    drive(1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("t6_clrdrop", 64'(o_drop_cnt), 64'd1);

    // reset while the drop counter is non-zero and the FIFO is full
    bus.i_valid = 1'b0;
    i_clr_status = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("end_drop",  64'(o_drop_cnt), 64'd0);
    chk("end_count", 64'(o_count),    64'd0);
    chk("end_full",  64'(o_full),     64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
